// File: rtl/univ_shiftreg.sv
// Universal shift register: hold/load/shift/rotate/arith-shift plus a sequenced
// multi-bit shift with busy/done. Optional parity output under UNIV_SHIFTREG_PARITY_EN.
module univ_shiftreg #(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       ctrl,
    input  logic [WIDTH-1:0] data_in,
    input  logic             shift_in_r,
    input  logic             shift_in_l,
    input  logic             dir,
    input  logic [SHW-1:0]   shamt,
    output logic [WIDTH-1:0] data_out,
    output logic             serial_out_r,
    output logic             serial_out_l,
    output logic             busy,
`ifdef UNIV_SHIFTREG_PARITY_EN
    output logic             parity,
`endif
    output logic             done
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [SHW-1:0] WIDTH_S = SHW'(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             done_q, done_d;
    logic [SHW-1:0]   amt;

    // Amounts beyond the register width saturate; the word is fully replaced by then.
    always_comb begin
        amt = (shamt > WIDTH_S) ? WIDTH_S : shamt;
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                case (ctrl)
                    3'b000: data_d = data_q;
                    3'b001: data_d = data_in;
                    3'b010: data_d = {shift_in_r, data_q[WIDTH-1:1]};
                    3'b011: data_d = {data_q[WIDTH-2:0], shift_in_l};
                    3'b100: data_d = {data_q[0], data_q[WIDTH-1:1]};
                    3'b101: data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
                    3'b110: data_d = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
                    default: begin
                        if (amt == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = RUN;
                            cnt_d   = amt;
                            dir_d   = dir;
                        end
                    end
                endcase
            end
            RUN: begin
                data_d = dir_q ? {data_q[WIDTH-2:0], shift_in_l}
                               : {shift_in_r, data_q[WIDTH-1:1]};
                cnt_d  = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
        end
    end

`ifdef UNIV_SHIFTREG_PARITY_EN
    logic parity_q;
    // Registered from the next value so it always matches the word on data_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) parity_q <= 1'b0;
        else        parity_q <= ^data_d;
    end
    assign parity = parity_q;
`endif

    assign data_out     = data_q;
    assign serial_out_r = data_q[0];
    assign serial_out_l = data_q[WIDTH-1];
    assign busy         = (state_q == RUN);
    assign done         = done_q;

endmodule

// File: tb/tb_univ_shiftreg.sv
// Randomized and directed bench for univ_shiftreg with a queue-based scoreboard.
module tb_univ_shiftreg;

    localparam int W   = 8;
    localparam int SHW = $clog2(W + 1);

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [2:0]     ctrl = '0;
    logic [W-1:0]   data_in = '0;
    logic           shift_in_r = 1'b0;
    logic           shift_in_l = 1'b0;
    logic           dir = 1'b0;
    logic [SHW-1:0] shamt = '0;
    logic [W-1:0]   data_out;
    logic           serial_out_r, serial_out_l, busy, done;
`ifdef UNIV_SHIFTREG_PARITY_EN
    logic           parity;
`endif

    univ_shiftreg #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .ctrl(ctrl), .data_in(data_in),
        .shift_in_r(shift_in_r), .shift_in_l(shift_in_l), .dir(dir), .shamt(shamt),
        .data_out(data_out), .serial_out_r(serial_out_r), .serial_out_l(serial_out_l),
        .busy(busy),
`ifdef UNIV_SHIFTREG_PARITY_EN
        .parity(parity),
`endif
        .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] data;
        logic         busy;
        logic         done;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: remaining shift count rather than any state encoding.
    logic [W-1:0] m_data = '0;
    int           m_rem  = 0;
    logic         m_dir  = 1'b0;
    logic         m_done = 1'b0;

    localparam logic [W-1:0] MSB = {1'b1, {(W-1){1'b0}}};

    function automatic logic [W-1:0] shr(input logic [W-1:0] d, input logic fill);
        return (d >> 1) | (fill ? MSB : '0);
    endfunction

    function automatic logic [W-1:0] shl(input logic [W-1:0] d, input logic fill);
        return (d << 1) | W'(fill);
    endfunction

    task automatic model_edge();
        int n;
        if (!rst_n) begin
            m_data = '0; m_rem = 0; m_done = 1'b0;
        end else if (m_rem > 0) begin
            m_data = m_dir ? shl(m_data, shift_in_l) : shr(m_data, shift_in_r);
            m_rem  = m_rem - 1;
            m_done = (m_rem == 0);
        end else begin
            m_done = 1'b0;
            case (ctrl)
                3'd1: m_data = data_in;
                3'd2: m_data = shr(m_data, shift_in_r);
                3'd3: m_data = shl(m_data, shift_in_l);
                3'd4: m_data = shr(m_data, m_data[0]);
                3'd5: m_data = shl(m_data, m_data[W-1]);
                3'd6: m_data = shr(m_data, m_data[W-1]);
                3'd7: begin
                    n = (int'(shamt) > W) ? W : int'(shamt);
                    if (n == 0) m_done = 1'b1;
                    else begin m_rem = n; m_dir = dir; end
                end
                default: ;
            endcase
        end
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Inputs are set before calling; one rising edge is consumed and its outcome queued.
    task automatic cycle();
        exp_t e;
        model_edge();
        e.data = m_data;
        e.busy = (m_rem > 0);
        e.done = m_done;
        exp_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic load(input logic [W-1:0] v);
        ctrl = 3'd1; data_in = v; cycle();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("mon_data", data_out, e.data);
            check("mon_busy", W'(busy), W'(e.busy));
            check("mon_done", W'(done), W'(e.done));
            check("mon_sr", W'(serial_out_r), W'(e.data[0]));
            check("mon_sl", W'(serial_out_l), W'(e.data[W-1]));
`ifdef UNIV_SHIFTREG_PARITY_EN
            check("mon_parity", W'(parity), W'(^e.data));
`endif
        end
    end

    initial begin
        // Reset state
        @(negedge clk); #1;
        check("reset_data", data_out, '0);
        check("reset_busy", W'(busy), '0);
        check("reset_done", W'(done), '0);
        cycle(); cycle();
        rst_n = 1'b1;

        load(8'hA5);
        check("load_a5", data_out, 8'hA5);
        ctrl = 3'd0; data_in = 8'h3C;
        repeat (3) cycle();
        check("hold_a5", data_out, 8'hA5);

        // Mid-cycle reset is immediate
        rst_n = 1'b0; #1;
        check("async_reset", data_out, '0);
        cycle();
        rst_n = 1'b1;

        load(8'hA5); ctrl = 3'd2; shift_in_r = 1'b1; cycle();
        check("shr_d2", data_out, 8'hD2);
        load(8'hA5); ctrl = 3'd3; shift_in_l = 1'b0; cycle();
        check("shl_4a", data_out, 8'h4A);
        load(8'h81); ctrl = 3'd4; cycle();
        check("ror_c0", data_out, 8'hC0);
        load(8'h81); ctrl = 3'd5; cycle();
        check("rol_03", data_out, 8'h03);
        load(8'h80); ctrl = 3'd6; cycle();
        check("asr_c0", data_out, 8'hC0);

        // Multi-shift right by 3; a load during busy must be ignored
        load(8'hF0);
        ctrl = 3'd7; dir = 1'b0; shamt = 4'd3; shift_in_r = 1'b0; cycle();
        check("ms_busy", W'(busy), 8'd1);
        ctrl = 3'd1; data_in = 8'h55;
        cycle(); cycle(); cycle();
        check("ms_1e", data_out, 8'h1E);
        check("ms_done", W'(done), 8'd1);
        check("ms_idle", W'(busy), '0);

        // Zero amount: done only
        ctrl = 3'd7; shamt = 4'd0; cycle();
        check("ms0_done", W'(done), 8'd1);
        check("ms0_busy", W'(busy), '0);
        check("ms0_data", data_out, 8'h1E);

        // Saturated amount
        ctrl = 3'd7; shamt = 4'd15; dir = 1'b1; shift_in_l = 1'b1; cycle();
        ctrl = 3'd0;
        repeat (7) cycle();
        check("ms15_busy", W'(busy), 8'd1);
        cycle();
        check("ms15_ff", data_out, 8'hFF);
        check("ms15_done", W'(done), 8'd1);

        // Reset mid-run aborts without done
        load(8'h0F);
        ctrl = 3'd7; shamt = 4'd5; dir = 1'b0; shift_in_r = 1'b1; cycle();
        ctrl = 3'd0; cycle(); cycle();
        rst_n = 1'b0; #1;
        check("abort_data", data_out, '0);
        check("abort_busy", W'(busy), '0);
        cycle();
        check("abort_done", W'(done), '0);
        rst_n = 1'b1;
        load(8'h3C);
        check("post_abort_load", data_out, 8'h3C);

`ifdef UNIV_SHIFTREG_PARITY_EN
        load(8'h07);
        check("parity_07", W'(parity), 8'd1);
        load(8'h03);
        check("parity_03", W'(parity), '0);
`endif

        // Random traffic; multi-shift starts biased rarer
        for (int i = 0; i < 2000; i++) begin
            ctrl       = ($urandom_range(0, 9) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
            data_in    = W'($urandom);
            shift_in_r = 1'($urandom);
            shift_in_l = 1'($urandom);
            dir        = 1'($urandom);
            shamt      = SHW'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0; #1;
                check("rand_async_reset", data_out, '0);
            end
            cycle();
            rst_n = 1'b1;
        end

        repeat (2) @(negedge clk);
        #1;
        check("queue_drained", W'(exp_q.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/univ_shiftreg.md
# univ_shiftreg

Parametrised universal synchronous shift register, the successor to the team's 8-bit hold/load/shift-right register. It adds configurable width, shifting in both directions, rotate, arithmetic shift, and a sequenced multi-bit shift with a busy/done handshake. It sits in the datapath as a general-purpose serialiser/deserialiser and barrel-shift substitute where area matters more than latency.

## Interface
- WIDTH, 8, register width in bits (≥2).
- SHW, $clog2(WIDTH+1) (localparam), width of shift-amount input.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ctrl  in  3  operation select (see Operation).
- data_in  in  WIDTH  parallel load data.
- shift_in_r  in  1  serial bit entering at MSB on right shifts.
- shift_in_l  in  1  serial bit entering at LSB on left shifts.
- dir  in  1  multi-shift direction: 0 right, 1 left.
- shamt  in  SHW  multi-shift amount.
- data_out  out  WIDTH  register contents.
- serial_out_r  out  1  data_out[0], continuous.
- serial_out_l  out  1  data_out[WIDTH-1], continuous.
- busy  out  1  multi-shift in progress.
- done  out  1  one-cycle pulse at multi-shift completion.
- parity  out  1  only with UNIV_SHIFTREG_PARITY_EN (see Configuration).

## Operation
- Reset (rst_n=0, immediate): data_out=0, busy=0, done=0, counter=0, state IDLE, parity=0.
- FSM states: IDLE, RUN.
- In IDLE, ctrl decodes each edge:
  - 000 hold: data_out unchanged (whole word, not a bit slice).
  - 001 load: data_out <= data_in.
  - 010 shift right: data_out <= {shift_in_r, data_out[WIDTH-1:1]}.
  - 011 shift left: data_out <= {data_out[WIDTH-2:0], shift_in_l}.
  - 100 rotate right; 101 rotate left (serial inputs ignored).
  - 110 arithmetic shift right: MSB replicated.
  - 111 multi-shift start: effective amount n = min(shamt, WIDTH); latch dir and n.
- Multi-shift, n=0: no state change to data; done=1 for the following cycle; busy stays 0; FSM stays IDLE.
- Multi-shift, n≥1: go to RUN, busy=1, counter=n. In each RUN cycle, shift one bit in the latched direction, filling from shift_in_r/shift_in_l as sampled that cycle, then decrement the counter. At the edge performing the last shift, go to IDLE with busy=0 and done=1 for one cycle.
- In RUN, ctrl, data_in, dir and shamt are ignored (no load, no restart).
- done is never asserted except as above. It clears at the next edge.

## Timing
- Single-step ops: result visible in data_out one edge after ctrl sampled; latency 1.
- Multi-shift started at edge k with n≥1:
  - shifts at edges k+1..k+n;
  - busy high from after edge k until after edge k+n;
  - done high for the cycle after edge k+n.
- New ctrl is accepted in the same cycle done is high (FSM already IDLE).
- Reset asserted mid-RUN aborts immediately to reset values; no done pulse.
- serial_out_r/serial_out_l are combinational from the register, so there is no extra latency.

## Configuration
- UNIV_SHIFTREG_PARITY_EN defined: parity output present; a registered XOR-reduction of the next data_out value, so parity equals ^data_out in the same cycle; reset 0.
- Not defined: parity port and logic absent; all other behaviour identical.

## Test plan
- Reset/load/hold: assert rst_n=0 mid-cycle → data_out=0 immediately. Load 8'hA5 with ctrl=001 → 8'hA5. Hold with ctrl=000 for 3 cycles → still 8'hA5.
- Single shifts, WIDTH=8, from 8'hA5:
  - ctrl=010, shift_in_r=1 → 8'hD2.
  - ctrl=011, shift_in_l=0 from 8'hA5 → 8'h4A.
  - ctrl=100 from 8'h81 → 8'hC0.
  - ctrl=110 from 8'h80 → 8'hC0.
- Multi-shift: load 8'hF0, dir=0, shamt=3, shift_in_r=0, ctrl=111 → busy high for 3 cycles, data_out=8'h1E, done pulse one cycle. A ctrl=001 during busy must be ignored.
- Boundaries:
  - shamt=0 → no busy, done pulse next cycle, data unchanged.
  - shamt=15 with WIDTH=8, dir=1, shift_in_l=1 → 8 shifts, data_out=8'hFF.
- Reset during RUN (after 2 of 5 shifts) → data_out=0, busy=0, no done. The next ctrl=001 loads normally.
- With UNIV_SHIFTREG_PARITY_EN: load 8'h07 → parity=1; load 8'h03 → parity=0.
